// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control unit: FETCH/EXEC/WB/HALT sequencer with a
// combinational control word decoded from the latched instruction register.
module legv8_control_unit #(
    parameter int DATA_W   = 64,
    parameter int LINK_REG = 30,
    parameter int ZERO_REG = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       iToCU,
    input  logic [3:0]        status,
    output logic [DATA_W-1:0] k,
    output logic [4:0]        DA,
    output logic [4:0]        SA,
    output logic [4:0]        SB,
    output logic [4:0]        FS,
    output logic [1:0]        PS,
    output logic [1:0]        dataMux,
    output logic              regW,
    output logic              ramW,
    output logic              R,
    output logic              PCsel,
    output logic              Bsel,
    output logic              halted
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR,
        OP_ADDI, OP_SUBI, OP_STUR, OP_LDUR, OP_CBZ, OP_CBNZ,
        OP_B, OP_BL, OP_BR, OP_BAD
    } op_t;

    state_t            r_state, w_next;
    logic [31:0]       r_ir;
    op_t               w_op;

    logic [4:0]        w_rd, w_rn, w_rm;
    logic [DATA_W-1:0] w_shamt, w_imm12, w_d9, w_cb19, w_br26;
    logic              w_unused_status;

    assign w_rd    = r_ir[4:0];
    assign w_rn    = r_ir[9:5];
    assign w_rm    = r_ir[20:16];
    assign w_shamt = DATA_W'(r_ir[15:10]);
    assign w_imm12 = DATA_W'(r_ir[21:10]);
    assign w_d9    = {{(DATA_W-9){r_ir[20]}}, r_ir[20:12]};
    assign w_cb19  = {{(DATA_W-19){r_ir[23]}}, r_ir[23:5]};
    assign w_br26  = {{(DATA_W-26){r_ir[25]}}, r_ir[25:0]};

    // Only the Z flag resolves branches; the other flags are not consumed here.
    assign w_unused_status = ^status[3:1];

    // State register and instruction latch; reset aborts any instruction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH)
                r_ir <= iToCU;
        end
    end

    // Opcode decode, widest pattern first so the first match wins.
    always_comb begin
        w_op = OP_BAD;
        case (r_ir[31:21])
            11'b10001011000: w_op = OP_ADD;
            11'b11001011000: w_op = OP_SUB;
            11'b10001010000: w_op = OP_AND;
            11'b10101010000: w_op = OP_ORR;
            11'b11001010000: w_op = OP_EOR;
            11'b11010011011: w_op = OP_LSL;
            11'b11010011010: w_op = OP_LSR;
            11'b11111000000: w_op = OP_STUR;
            11'b11111000010: w_op = OP_LDUR;
            11'b11010110000: w_op = OP_BR;
            default: begin
                case (r_ir[31:22])
                    10'b1001000100: w_op = OP_ADDI;
                    10'b1101000100: w_op = OP_SUBI;
                    default: begin
                        case (r_ir[31:24])
                            8'b10110100: w_op = OP_CBZ;
                            8'b10110101: w_op = OP_CBNZ;
                            default: begin
                                case (r_ir[31:26])
                                    6'b000101: w_op = OP_B;
                                    6'b100101: w_op = OP_BL;
                                    default:   w_op = OP_BAD;
                                endcase
                            end
                        endcase
                    end
                endcase
            end
        endcase
    end

    // Next state and control word; everything idles at zero unless a state drives it.
    always_comb begin
        k       = '0;
        DA      = '0;
        SA      = '0;
        SB      = '0;
        FS      = '0;
        PS      = 2'b00;
        dataMux = 2'b00;
        regW    = 1'b0;
        ramW    = 1'b0;
        R       = 1'b0;
        PCsel   = 1'b0;
        Bsel    = 1'b0;
        halted  = 1'b0;
        w_next  = r_state;
        case (r_state)
            S_FETCH: w_next = S_EXEC;
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR: begin
                        DA   = w_rd;
                        SA   = w_rn;
                        SB   = w_rm;
                        regW = 1'b1;
                        PS   = 2'b01;
                        case (w_op)
                            OP_ADD: FS = 5'b01000;
                            OP_SUB: FS = 5'b01001;
                            OP_AND: FS = 5'b00000;
                            OP_ORR: FS = 5'b00100;
                            OP_EOR: FS = 5'b01100;
                            OP_LSL: begin FS = 5'b10000; k = w_shamt; Bsel = 1'b1; end
                            OP_LSR: begin FS = 5'b10100; k = w_shamt; Bsel = 1'b1; end
                            default: FS = 5'b00000;
                        endcase
                    end
                    OP_ADDI, OP_SUBI: begin
                        DA   = w_rd;
                        SA   = w_rn;
                        k    = w_imm12;
                        Bsel = 1'b1;
                        FS   = (w_op == OP_SUBI) ? 5'b01001 : 5'b01000;
                        regW = 1'b1;
                        PS   = 2'b01;
                    end
                    OP_STUR, OP_LDUR: begin
                        SA   = w_rn;
                        SB   = w_rd;
                        k    = w_d9;
                        Bsel = 1'b1;
                        FS   = 5'b01000;
                        if (w_op == OP_STUR) begin
                            ramW = 1'b1;
                            PS   = 2'b01;
                        end else begin
                            R      = 1'b1;
                            w_next = S_WB;
                        end
                    end
                    OP_CBZ, OP_CBNZ: begin
                        SA = 5'(ZERO_REG);
                        SB = w_rd;
                        FS = 5'b00100;
                        k  = w_cb19;
                        if (status[0] == (w_op == OP_CBZ)) begin
                            PS    = 2'b10;
                            PCsel = 1'b1;
                        end else begin
                            PS = 2'b01;
                        end
                    end
                    OP_B, OP_BL: begin
                        k     = w_br26;
                        PS    = 2'b10;
                        PCsel = 1'b1;
                        if (w_op == OP_BL) begin
                            DA      = 5'(LINK_REG);
                            dataMux = 2'b10;
                            regW    = 1'b1;
                        end
                    end
                    OP_BR: begin
                        SA = w_rn;
                        PS = 2'b10;
                    end
                    default: w_next = S_HALT;
                endcase
            end
            S_WB: begin
                // Load address path stays stable while the RAM data is written back.
                SA      = w_rn;
                SB      = w_rd;
                k       = w_d9;
                Bsel    = 1'b1;
                FS      = 5'b01000;
                DA      = w_rd;
                R       = 1'b1;
                dataMux = 2'b01;
                regW    = 1'b1;
                PS      = 2'b01;
                w_next  = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_legv8_control_unit.sv
// Bench for legv8_control_unit: hand-computed vector table, reset/halt
// sequences, then random instructions checked against a mnemonic-level model.
module tb_legv8_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] iToCU = '0;
    logic [3:0]  status = '0;
    logic [63:0] k;
    logic [4:0]  DA, SA, SB, FS;
    logic [1:0]  PS, dataMux;
    logic        regW, ramW, R, PCsel, Bsel, halted;

    legv8_control_unit dut (
        .clock(clock), .reset(reset), .iToCU(iToCU), .status(status),
        .k(k), .DA(DA), .SA(SA), .SB(SB), .FS(FS), .PS(PS), .dataMux(dataMux),
        .regW(regW), .ramW(ramW), .R(R), .PCsel(PCsel), .Bsel(Bsel), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] k;
        logic [4:0]  da, sa, sb, fs;
        logic [1:0]  ps, dm;
        logic        rw, mw, r, pc, bs, hl;
    } ctl_t;

    typedef struct {
        string       nm;
        logic [31:0] ins;
        logic [3:0]  st;
        ctl_t        ex;
        bit          has_wb;
        ctl_t        wb;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vt[$];

    function automatic ctl_t mk(longint kk, int da, int sa, int sb, int fs, int ps, int dm,
                                bit rw, bit mw, bit r, bit pc, bit bs);
        ctl_t c;
        c.k = kk; c.da = 5'(da); c.sa = 5'(sa); c.sb = 5'(sb); c.fs = 5'(fs);
        c.ps = 2'(ps); c.dm = 2'(dm); c.rw = rw; c.mw = mw; c.r = r; c.pc = pc; c.bs = bs;
        c.hl = 1'b0;
        return c;
    endfunction

    function automatic ctl_t halt_ctl();
        ctl_t c = '0;
        c.hl = 1'b1;
        return c;
    endfunction

    function automatic ctl_t get_dut();
        ctl_t c;
        c.k = k; c.da = DA; c.sa = SA; c.sb = SB; c.fs = FS; c.ps = PS; c.dm = dataMux;
        c.rw = regW; c.mw = ramW; c.r = R; c.pc = PCsel; c.bs = Bsel; c.hl = halted;
        return c;
    endfunction

    task automatic check(input string nm, input ctl_t exp);
        ctl_t got = get_dut();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reset held across one edge, released 1 time unit after the edge.
    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------- reference model (mnemonic level) ----------------
    function automatic string mnem(logic [31:0] ins);
        int unsigned u = ins;
        case (u >> 21)
            'h458: return "ADD";  'h658: return "SUB";  'h450: return "AND";
            'h550: return "ORR";  'h650: return "EOR";  'h69B: return "LSL";
            'h69A: return "LSR";  'h7C0: return "STUR"; 'h7C2: return "LDUR";
            'h6B0: return "BR";
            default: ;
        endcase
        case (u >> 22)
            'h244: return "ADDI"; 'h344: return "SUBI";
            default: ;
        endcase
        case (u >> 24)
            'hB4: return "CBZ"; 'hB5: return "CBNZ";
            default: ;
        endcase
        case (u >> 26)
            'h05: return "B"; 'h25: return "BL";
            default: ;
        endcase
        return "";
    endfunction

    function automatic longint sx(int unsigned v, int bits);
        if (v >= (32'd1 << (bits - 1))) return longint'(v) - (longint'(1) << bits);
        return longint'(v);
    endfunction

    // phase 0 = execute cycle, 1 = load write-back cycle
    function automatic ctl_t model(logic [31:0] ins, logic [3:0] st, int phase);
        int unsigned u = ins;
        int rd = u % 32, rn = (u / 32) % 32, rm = (u >> 16) % 32, sh = (u >> 10) % 64;
        longint imm12 = (u >> 10) % 4096;
        longint d9 = sx((u >> 12) % 512, 9);
        longint c19 = sx((u >> 5) % (1 << 19), 19);
        longint b26 = sx(u % (1 << 26), 26);
        string m = mnem(ins);
        bit z = st[0];
        bit taken;
        if (m == "ADD")  return mk(0, rd, rn, rm, 8, 1, 0, 1, 0, 0, 0, 0);
        if (m == "SUB")  return mk(0, rd, rn, rm, 9, 1, 0, 1, 0, 0, 0, 0);
        if (m == "AND")  return mk(0, rd, rn, rm, 0, 1, 0, 1, 0, 0, 0, 0);
        if (m == "ORR")  return mk(0, rd, rn, rm, 4, 1, 0, 1, 0, 0, 0, 0);
        if (m == "EOR")  return mk(0, rd, rn, rm, 12, 1, 0, 1, 0, 0, 0, 0);
        if (m == "LSL")  return mk(sh, rd, rn, rm, 16, 1, 0, 1, 0, 0, 0, 1);
        if (m == "LSR")  return mk(sh, rd, rn, rm, 20, 1, 0, 1, 0, 0, 0, 1);
        if (m == "ADDI") return mk(imm12, rd, rn, 0, 8, 1, 0, 1, 0, 0, 0, 1);
        if (m == "SUBI") return mk(imm12, rd, rn, 0, 9, 1, 0, 1, 0, 0, 0, 1);
        if (m == "STUR") return mk(d9, 0, rn, rd, 8, 1, 0, 0, 1, 0, 0, 1);
        if (m == "LDUR") begin
            if (phase == 0) return mk(d9, 0, rn, rd, 8, 0, 0, 0, 0, 1, 0, 1);
            return mk(d9, rd, rn, rd, 8, 1, 1, 1, 0, 1, 0, 1);
        end
        if (m == "CBZ" || m == "CBNZ") begin
            taken = (m == "CBZ") ? z : !z;
            return mk(c19, 0, 31, rd, 4, taken ? 2 : 1, 0, 0, 0, 0, taken, 0);
        end
        if (m == "B")  return mk(b26, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0);
        if (m == "BL") return mk(b26, 30, 0, 0, 0, 2, 2, 1, 0, 0, 1, 0);
        if (m == "BR") return mk(0, 0, rn, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        return '0;
    endfunction

    // Runs one instruction from FETCH through its last cycle, checking every cycle.
    task automatic run_model(input string nm, input logic [31:0] ins, input logic [3:0] st);
        string m = mnem(ins);
        int pcnt = 0;
        iToCU = ins; status = st;
        step();
        check({nm, "_ex_", m}, model(ins, st, 0));
        if (PS != 2'b00) pcnt++;
        if (m == "LDUR") begin
            step();
            check({nm, "_wb"}, model(ins, st, 1));
            if (PS != 2'b00) pcnt++;
        end
        step();
        if (m == "") begin
            check({nm, "_halt"}, halt_ctl());
            do_reset();
        end else begin
            check({nm, "_fetch"}, ctl_t'('0));
            check_int({nm, "_ps_once"}, pcnt, 1);
        end
    endtask

    logic [31:0] tmpl_base [16] = '{
        32'h8B000000, 32'hCB000000, 32'h8A000000, 32'hAA000000, 32'hCA000000,
        32'hD3600000, 32'hD3400000, 32'h91000000, 32'hD1000000, 32'hF8000000,
        32'hF8400000, 32'hB4000000, 32'hB5000000, 32'h14000000, 32'h94000000,
        32'hD6000000};
    logic [31:0] tmpl_mask [16] = '{
        32'h1FFFFF, 32'h1FFFFF, 32'h1FFFFF, 32'h1FFFFF, 32'h1FFFFF,
        32'h1FFFFF, 32'h1FFFFF, 32'h3FFFFF, 32'h3FFFFF, 32'h1FFFFF,
        32'h1FFFFF, 32'hFFFFFF, 32'hFFFFFF, 32'h3FFFFFF, 32'h3FFFFFF,
        32'h1FFFFF};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t add_ex;
        add_ex = mk(0, 7, 1, 2, 'b01000, 1, 0, 1, 0, 0, 0, 0);
        vt.push_back('{"add",    32'h8B020027, 4'h0, add_ex, 0, '0});
        vt.push_back('{"add_xzr",32'h8B02003F, 4'h0, mk(0, 31, 1, 2, 'b01000, 1, 0, 1, 0, 0, 0, 0), 0, '0});
        vt.push_back('{"sub",    32'hCB050083, 4'h0, mk(0, 3, 4, 5, 'b01001, 1, 0, 1, 0, 0, 0, 0), 0, '0});
        vt.push_back('{"lsl",    32'hD3600C41, 4'h0, mk(3, 1, 2, 0, 'b10000, 1, 0, 1, 0, 0, 0, 1), 0, '0});
        vt.push_back('{"addi",   32'h913FFD49, 4'h0, mk('hFFF, 9, 10, 0, 'b01000, 1, 0, 1, 0, 0, 0, 1), 0, '0});
        vt.push_back('{"stur",   32'hF81FF0E6, 4'h0, mk(-1, 0, 7, 6, 'b01000, 1, 0, 0, 1, 0, 0, 1), 0, '0});
        vt.push_back('{"ldur",   32'hF8408023, 4'h0, mk(8, 0, 1, 3, 'b01000, 0, 0, 0, 0, 1, 0, 1),
                       1, mk(8, 3, 1, 3, 'b01000, 1, 1, 1, 0, 1, 0, 1)});
        vt.push_back('{"cbz_t",  32'hB4FFFFC5, 4'h1, mk(-2, 0, 31, 5, 'b00100, 2, 0, 0, 0, 0, 1, 0), 0, '0});
        vt.push_back('{"cbz_nt", 32'hB4FFFFC5, 4'hE, mk(-2, 0, 31, 5, 'b00100, 1, 0, 0, 0, 0, 0, 0), 0, '0});
        vt.push_back('{"cbnz_t", 32'hB5000042, 4'h0, mk(2, 0, 31, 2, 'b00100, 2, 0, 0, 0, 0, 1, 0), 0, '0});
        vt.push_back('{"cbnz_nt",32'hB5000042, 4'hF, mk(2, 0, 31, 2, 'b00100, 1, 0, 0, 0, 0, 0, 0), 0, '0});
        vt.push_back('{"b_neg",  32'h17FFFFFF, 4'h0, mk(-1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0), 0, '0});
        vt.push_back('{"bl",     32'h94000004, 4'h0, mk(4, 30, 0, 0, 0, 2, 2, 1, 0, 0, 1, 0), 0, '0});
        vt.push_back('{"br",     32'hD60003C0, 4'h0, mk(0, 0, 30, 0, 0, 2, 0, 0, 0, 0, 0, 0), 0, '0});

        // reset state
        #3;
        check("reset_outputs", ctl_t'('0));
        step();
        reset = 1'b0;

        // hand-computed vector table
        foreach (vt[i]) begin
            iToCU = vt[i].ins; status = vt[i].st;
            step();
            check({vt[i].nm, "_ex"}, vt[i].ex);
            if (vt[i].has_wb) begin
                step();
                check({vt[i].nm, "_wb"}, vt[i].wb);
            end
            step();
            check({vt[i].nm, "_fetch"}, ctl_t'('0));
        end

        // reset asserted mid-EXEC of ADD clears outputs without waiting for an edge
        iToCU = 32'h8B020027; status = 4'h0;
        step();
        check("rst_pre_exec", add_ex);
        #2 reset = 1'b1;
        #1 check("rst_async_zero", ctl_t'('0));
        step();
        check("rst_held_zero", ctl_t'('0));
        reset = 1'b0;
        iToCU = 32'hCB050083;
        step();
        check("rst_then_fetch", mk(0, 3, 4, 5, 'b01001, 1, 0, 1, 0, 0, 0, 0));
        step();

        // unknown opcode halts and ignores the instruction bus until reset
        iToCU = 32'h0000_0000;
        step();
        check("halt_exec_idle", ctl_t'('0));
        for (int c = 0; c < 10; c++) begin
            iToCU = $urandom;
            step();
            check($sformatf("halt_hold%0d", c), halt_ctl());
        end
        reset = 1'b1;
        #1 check("halt_reset_clear", ctl_t'('0));
        step();
        reset = 1'b0;

        // random instructions against the model
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins;
            int sel = $urandom_range(0, 19);
            if (sel < 16) ins = tmpl_base[sel] | (32'($urandom) & tmpl_mask[sel]);
            else          ins = $urandom;
            run_model($sformatf("rnd%0d", n), ins, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
